sdram_dq_datapath: RTL
======================

// Module: sdram_dq_datapath
// PURPOSE
//  Data-path sequencer between the SDRAM command scheduler and the per-bit DQ pad buffers.
//  - Writes: on each WRITE command strobe, pulls one burst of write data from the
//    controller and drives dq_o/dq_oe/dqm so each beat reaches the pins together with
//    the command.
//  - Reads: on each READ command strobe, counts out CAS latency plus the pad-path
//    register delay, then captures the returning burst from dq_i into a valid-qualified
//    read stream.
// PARAMETERS
//  W_DATA        16  SDRAM DQ width in bits
//  BURST_LEN     4   beats per burst, fixed (1,2,4,8)
//  CAS_LATENCY   2   device CL in clk cycles (2 or 3)
//  PHY_RD_DELAY  2   cycles from READ strobe to pin (1) plus input pad register (1)
// PORTS
//  clk           in   1          system clock, same clock as DQ pad buffers
//  rst_n         in   1          reset, asynchronous assert, active-low
//  cmd_write     in   1          pulse: scheduler issues WRITE this cycle
//  cmd_read      in   1          pulse: scheduler issues READ this cycle
//  wdata         in   W_DATA     write beat from controller write buffer
//  wmask         in   W_DATA/8   per-byte write mask, 1 = do not write
//  wdata_valid   in   1          wdata/wmask valid
//  wdata_ready   out  1          beat consumed this cycle
//  dq_o          out  W_DATA     to pad buffers, core->pad data
//  dq_oe         out  1          to pad buffers, active-high output enable
//  dq_i          in   W_DATA     from pad buffers, registered pad data
//  dqm           out  W_DATA/8   to DQM output registers
//  rdata         out  W_DATA     captured read beat
//  rdata_valid   out  1          rdata valid, one pulse per beat
//  wr_active     out  1          write burst in progress
//  rd_pending    out  1          any read beat still outstanding
//  err_underflow out  1          sticky: wdata_valid low on a required write beat
//  err_conflict  out  1          sticky: WRITE would drive DQ while read data is due
// BEHAVIOUR
//  Reset values: all outputs 0; beat counter and read tracker cleared; sticky errors cleared.
//  Reset mid-burst abandons the burst immediately: dq_oe=0, no rdata_valid after deassertion.
//  Write path (cycle T = cmd_write strobe):
//   - Beat k (0..BURST_LEN-1) is presented at cycle T+k.
//   - In that cycle: wdata_ready=1, dq_o=wdata, dqm=wmask, dq_oe=1.
//     Pad buffers register these, so pins match the command at T+1.
//   - wdata_ready is combinational from the beat counter and cmd_write, never from wdata_valid.
//   - If wdata_valid=0 on a beat: beat still driven with dqm all-1s (masked);
//     err_underflow sets.
//   - cmd_write during an active write burst: write interrupt; beat counter restarts
//     at 0 from that cycle.
//   - When not writing: dq_oe=0, dqm=0 (reads require DQM low), dq_o holds last value.
//  Read path (cycle T = cmd_read strobe):
//   - Beats appear on dq_i at T+CAS_LATENCY+PHY_RD_DELAY+k, k=0..BURST_LEN-1.
//   - Track them with a valid shift register of depth
//     CAS_LATENCY+PHY_RD_DELAY+BURST_LEN-1, loaded by OR, so back-to-back and
//     interrupting reads overlap correctly.
//   - rdata is a registered capture of dq_i: rdata_valid and rdata both update on
//     the clk edge after the dq_i beat, i.e. one cycle later.
//   - rd_pending = OR of the tracker bits.
//  Simultaneous cmd_write and cmd_read: protocol error. The write is processed, the read
//   is dropped, and err_conflict sets.
//  err_conflict also sets if cmd_write arrives while any read beat is due on the pins
//   at cycle >= T+1. The write still proceeds, because the scheduler owns turnaround.
//  Read during an active write: allowed (read interrupts write). The write burst
//   terminates that cycle, and dq_oe drops the same cycle cmd_read is seen.
//  Widths: W_DATA multiple of 8; BURST_LEN a power of 2; beat counter is clog2(BURST_LEN)+1 bits.
// STRUCTURE
//  sdram_pkg: burst-length/CL encodings, W_DATA default, tracker-depth function.
//  One sub-module: sdram_rd_tracker (parameterised valid shift register; outputs
//   capture-enable and rd_pending).
//  The pad buffers are instantiated at top level, outside this block.
// TESTING
//  1. Single write, BURST_LEN=4, data A0..A3 valid:
//     -> wdata_ready and dq_oe high at T..T+3; dq_o=A0..A3; dqm=0; wr_active falls at T+4.
//  2. Single read, CL=2: drive dq_i=B0..B3 at T+4..T+7
//     -> rdata_valid at T+5..T+8 carrying B0..B3; rd_pending low at T+8.
//  3. Back-to-back reads at T and T+4 -> 8 contiguous rdata_valid pulses, no gap.
//     Then a read at T+2 interrupting the first -> 6 pulses.
//  4. Write with wdata_valid=0 on beat 2 -> dqm=all-1s on that beat; err_underflow set, stays set.
//  5. Read at T, write at T+3
//     -> err_conflict set. Also cmd_read=cmd_write=1 -> write only, err_conflict set.
//  6. Assert rst_n low at beat 1 of a write and mid-read
//     -> all outputs 0 asynchronously; no rdata_valid after release.

Source files
------------

// File: rtl/sdram_dq_datapath_pkg.sv
// Shared constants, mode-register encodings and sizing helpers for the SDRAM DQ datapath.
package sdram_dq_datapath_pkg;

    localparam int W_DATA_DEFAULT       = 16;
    localparam int BURST_LEN_DEFAULT    = 4;
    localparam int CAS_LATENCY_DEFAULT  = 2;
    localparam int PHY_RD_DELAY_DEFAULT = 2;

    typedef enum logic [2:0] {
        MR_BL_1 = 3'd0,
        MR_BL_2 = 3'd1,
        MR_BL_4 = 3'd2,
        MR_BL_8 = 3'd3
    } mr_burst_len_e;

    typedef enum logic [2:0] {
        MR_CL_2 = 3'd2,
        MR_CL_3 = 3'd3
    } mr_cas_latency_e;

    // One bit per cycle from the cycle after READ up to the last returning beat.
    function automatic int tracker_depth(input int cl, input int phy, input int bl);
        return cl + phy + bl - 1;
    endfunction

endpackage

// File: rtl/sdram_dq_datapath_if.sv
// Scheduler/controller/pad-side signal bundle of the SDRAM DQ datapath.
interface sdram_dq_datapath_if
    import sdram_dq_datapath_pkg::*;
#(
    parameter int W_DATA = W_DATA_DEFAULT
);
    localparam int W_MASK = W_DATA / 8;

    logic              cmd_write;
    logic              cmd_read;
    logic [W_DATA-1:0] wdata;
    logic [W_MASK-1:0] wmask;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [W_DATA-1:0] dq_o;
    logic              dq_oe;
    logic [W_DATA-1:0] dq_i;
    logic [W_MASK-1:0] dqm;
    logic [W_DATA-1:0] rdata;
    logic              rdata_valid;
    logic              wr_active;
    logic              rd_pending;
    logic              err_underflow;
    logic              err_conflict;

    modport master (
        output cmd_write, cmd_read, wdata, wmask, wdata_valid, dq_i,
        input  wdata_ready, dq_o, dq_oe, dqm, rdata, rdata_valid,
               wr_active, rd_pending, err_underflow, err_conflict
    );

    modport slave (
        input  cmd_write, cmd_read, wdata, wmask, wdata_valid, dq_i,
        output wdata_ready, dq_o, dq_oe, dqm, rdata, rdata_valid,
               wr_active, rd_pending, err_underflow, err_conflict
    );

endinterface

// File: rtl/sdram_dq_datapath_rd_tracker.sv
// Read-return tracker: bit j of the shift register means a read beat arrives on dq_i j cycles from now.
module sdram_dq_datapath_rd_tracker
    import sdram_dq_datapath_pkg::*;
#(
    parameter int CAS_LATENCY  = CAS_LATENCY_DEFAULT,
    parameter int PHY_RD_DELAY = PHY_RD_DELAY_DEFAULT,
    parameter int BURST_LEN    = BURST_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    output logic cap_en_o,
    output logic rd_pending_o,
    output logic due_late_o
);
    localparam int DEPTH = tracker_depth(CAS_LATENCY, PHY_RD_DELAY, BURST_LEN);
    localparam int LAT   = CAS_LATENCY + PHY_RD_DELAY;
    localparam logic [DEPTH-1:0] LOAD_MASK = DEPTH'(((1 << BURST_LEN) - 1) << (LAT - 1));

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // OR-loading lets overlapping and back-to-back reads merge into one return window.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sr
        if (gi == DEPTH - 1) begin : g_top
            assign sr_d[gi] = load_i & LOAD_MASK[gi];
        end else begin : g_mid
            assign sr_d[gi] = sr_q[gi+1] | (load_i & LOAD_MASK[gi]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign cap_en_o     = sr_q[0];
    assign rd_pending_o = |sr_q;
    // A beat on dq_i two or more cycles out is still ahead of the pins next cycle.
    assign due_late_o   = |sr_q[DEPTH-1:2];

endmodule

// File: rtl/sdram_dq_datapath.sv
// DQ data-path sequencer: write-burst beat sequencing toward the pads and read-burst capture from them.
module sdram_dq_datapath
    import sdram_dq_datapath_pkg::*;
#(
    parameter int W_DATA       = W_DATA_DEFAULT,
    parameter int BURST_LEN    = BURST_LEN_DEFAULT,
    parameter int CAS_LATENCY  = CAS_LATENCY_DEFAULT,
    parameter int PHY_RD_DELAY = PHY_RD_DELAY_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    sdram_dq_datapath_if.slave  bus
);
    localparam int W_MASK = W_DATA / 8;
    localparam int CW     = $clog2(BURST_LEN) + 1;
    localparam int LAST   = BURST_LEN - 1;

    logic [CW-1:0]     beat_q, beat_d;
    logic [W_DATA-1:0] dq_hold_q;
    logic [W_DATA-1:0] rdata_q;
    logic              rdata_valid_q;
    logic              err_underflow_q;
    logic              err_conflict_q;
    logic              wr_busy;
    logic              driving;
    logic              rd_load;
    logic              cap_en;
    logic              rd_pending;
    logic              rd_due_late;

    // beat_q holds the index of the next beat; zero means no burst continuing.
    assign wr_busy = (beat_q != '0);
    assign driving = rst_n & (bus.cmd_write | (wr_busy & ~bus.cmd_read));
    assign rd_load = bus.cmd_read & ~bus.cmd_write;

    always_comb begin
        beat_d = beat_q;
        if (bus.cmd_write) begin
            beat_d = (LAST == 0) ? '0 : CW'(1);
        end else if (bus.cmd_read) begin
            beat_d = '0;
        end else if (wr_busy) begin
            beat_d = (beat_q == CW'(LAST)) ? '0 : beat_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q          <= '0;
            dq_hold_q       <= '0;
            rdata_q         <= '0;
            rdata_valid_q   <= 1'b0;
            err_underflow_q <= 1'b0;
            err_conflict_q  <= 1'b0;
        end else begin
            beat_q        <= beat_d;
            rdata_valid_q <= cap_en;
            if (driving) begin
                dq_hold_q <= bus.wdata;
            end
            if (cap_en) begin
                rdata_q <= bus.dq_i;
            end
            if (driving && !bus.wdata_valid) begin
                err_underflow_q <= 1'b1;
            end
            if (bus.cmd_write && (bus.cmd_read || rd_due_late)) begin
                err_conflict_q <= 1'b1;
            end
        end
    end

    sdram_dq_datapath_rd_tracker #(
        .CAS_LATENCY  (CAS_LATENCY),
        .PHY_RD_DELAY (PHY_RD_DELAY),
        .BURST_LEN    (BURST_LEN)
    ) u_rd_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (rd_load),
        .cap_en_o     (cap_en),
        .rd_pending_o (rd_pending),
        .due_late_o   (rd_due_late)
    );

    assign bus.wdata_ready   = driving;
    assign bus.dq_oe         = driving;
    assign bus.wr_active     = driving;
    assign bus.dq_o          = driving ? bus.wdata : dq_hold_q;
    // A starved beat is still driven but masked so the device ignores it.
    assign bus.dqm           = driving ? (bus.wdata_valid ? bus.wmask : {W_MASK{1'b1}}) : '0;
    assign bus.rdata         = rdata_q;
    assign bus.rdata_valid   = rdata_valid_q;
    assign bus.rd_pending    = rd_pending;
    assign bus.err_underflow = err_underflow_q;
    assign bus.err_conflict  = err_conflict_q;

endmodule
